// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction ROM port, branch redirect, and the IF/ID handshake toward decode.
// The fetch stage is the master; the ROM, redirect source and decode stage together form the slave side.
interface fetch_stage_if #(
    parameter int N  = 64,
    parameter int IW = 32
);
    logic [7:0]    imem_addr;
    logic [IW-1:0] imem_q;
    logic          redirect;
    logic [N-1:0]  redirect_pc;
    logic [IW-1:0] instr_o;
    logic [N-1:0]  pc_o;
    logic          valid_o;
    logic          ready_i;
    logic          halted_o;
    logic [31:0]   fetch_cnt;

    modport master (
        output imem_addr, instr_o, pc_o, valid_o, halted_o, fetch_cnt,
        input  imem_q, redirect, redirect_pc, ready_i
    );

    modport slave (
        input  imem_addr, instr_o, pc_o, valid_o, halted_o, fetch_cnt,
        output imem_q, redirect, redirect_pc, ready_i
    );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: owns the PC, reads a combinational ROM and holds one instruction
// in an IF/ID slot with valid/ready toward decode. A zero word halts fetch until redirected.
module fetch_stage #(
    parameter int N  = 64,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  pc, pc_nxt;
    logic [N-1:0]  pc_o_r, pc_o_nxt;
    logic [IW-1:0] instr_r, instr_nxt;
    logic          valid_r, valid_nxt;
    logic [31:0]   cnt_r, cnt_nxt;
    logic          handshake;
    logic          slot_free;

    assign handshake = valid_r & bus.ready_i;
    assign slot_free = ~valid_r | bus.ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            pc      <= '0;
            pc_o_r  <= '0;
            instr_r <= '0;
            valid_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pc_o_r  <= pc_o_nxt;
            instr_r <= instr_nxt;
            valid_r <= valid_nxt;
            cnt_r   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pc_o_nxt  = pc_o_r;
        instr_nxt = instr_r;
        valid_nxt = valid_r;
        cnt_nxt   = cnt_r;

        // A handshake completing alongside a redirect still counts as delivered.
        if (handshake)
            cnt_nxt = cnt_r + 32'd1;

        if (bus.redirect) begin
            pc_nxt    = bus.redirect_pc & ~N'(3);
            valid_nxt = 1'b0;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (slot_free) begin
                        if (bus.imem_q != '0) begin
                            instr_nxt = bus.imem_q;
                            pc_o_nxt  = pc;
                            valid_nxt = 1'b1;
                            pc_nxt    = pc + N'(4);
                        end else begin
                            // PC stays on the zero word; it is never handed to decode.
                            state_nxt = HALT;
                            valid_nxt = 1'b0;
                        end
                    end
                end
                HALT: begin
                    if (handshake)
                        valid_nxt = 1'b0;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign bus.imem_addr = pc[9:2];
    assign bus.instr_o   = instr_r;
    assign bus.pc_o      = pc_o_r;
    assign bus.valid_o   = valid_r;
    assign bus.halted_o  = (state == HALT);
    assign bus.fetch_cnt = cnt_r;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table for fetch/backpressure/redirect/wrap, hand sequences for
// halt and mid-cycle async reset, and a scoreboard checking every instruction accepted by decode.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.N(64), .IW(32)) bus ();

    fetch_stage #(.N(64), .IW(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [256];
    assign bus.imem_q = rom[bus.imem_addr];

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        rdy;
        logic        rdr;
        logic [63:0] rpc;
        logic        push;
        logic        vld;
        logic [63:0] pco;
        logic [31:0] ins;
        logic [7:0]  addr;
        logic [31:0] cnt;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [31:0] romw(int i);
        return 32'hf8000001 + 32'(i) * 32'h00008001;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(logic [63:0] pc, logic [31:0] ins);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
        sbq.push_back(e);
    endtask

    // Every handshake seen by decode must match the oldest expected delivery.
    always @(negedge clk) begin
        if (!reset && bus.valid_o && bus.ready_i) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got handshake at pc %h expected none", bus.pc_o);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_pc", bus.pc_o, e.pc);
                chk("sb_instr", 64'(bus.instr_o), 64'(e.ins));
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = romw(i);
        rom[93] = 32'h0;
        bus.ready_i     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'd0;

        tbl[0]  = '{1'b1, 1'b0, 64'd0,     1'b1, 1'b1, 64'd0,     romw(0),   8'h01, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 64'd0,     1'b1, 1'b1, 64'd4,     romw(1),   8'h02, 32'd1};
        tbl[2]  = '{1'b1, 1'b0, 64'd0,     1'b1, 1'b1, 64'd8,     romw(2),   8'h03, 32'd2};
        tbl[3]  = '{1'b0, 1'b0, 64'd0,     1'b0, 1'b1, 64'd8,     romw(2),   8'h03, 32'd2};
        tbl[4]  = '{1'b0, 1'b0, 64'd0,     1'b0, 1'b1, 64'd8,     romw(2),   8'h03, 32'd2};
        tbl[5]  = '{1'b0, 1'b0, 64'd0,     1'b0, 1'b1, 64'd8,     romw(2),   8'h03, 32'd2};
        tbl[6]  = '{1'b1, 1'b0, 64'd0,     1'b0, 1'b1, 64'd12,    romw(3),   8'h04, 32'd3};
        tbl[7]  = '{1'b0, 1'b1, 64'h103,   1'b0, 1'b0, 64'd12,    romw(3),   8'h40, 32'd3};
        tbl[8]  = '{1'b0, 1'b0, 64'd0,     1'b1, 1'b1, 64'h100,   romw(64),  8'h41, 32'd3};
        tbl[9]  = '{1'b1, 1'b0, 64'd0,     1'b1, 1'b1, 64'h104,   romw(65),  8'h42, 32'd4};
        tbl[10] = '{1'b1, 1'b1, 64'h3FC,   1'b0, 1'b0, 64'h104,   romw(65),  8'hFF, 32'd5};
        tbl[11] = '{1'b1, 1'b0, 64'd0,     1'b1, 1'b1, 64'h3FC,   romw(255), 8'h00, 32'd5};
        tbl[12] = '{1'b1, 1'b0, 64'd0,     1'b1, 1'b1, 64'h400,   romw(0),   8'h01, 32'd6};
        tbl[13] = '{1'b0, 1'b0, 64'd0,     1'b0, 1'b1, 64'h400,   romw(0),   8'h01, 32'd6};
        tbl[14] = '{1'b1, 1'b1, 64'd0,     1'b0, 1'b0, 64'h400,   romw(0),   8'h00, 32'd7};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  64'(bus.valid_o),   64'd0);
        chk("rst_pc_o",   bus.pc_o,           64'd0);
        chk("rst_instr",  64'(bus.instr_o),   64'd0);
        chk("rst_addr",   64'(bus.imem_addr), 64'd0);
        chk("rst_halted", 64'(bus.halted_o),  64'd0);
        chk("rst_cnt",    64'(bus.fetch_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 15; r++) begin
            bus.ready_i     = tbl[r].rdy;
            bus.redirect    = tbl[r].rdr;
            bus.redirect_pc = tbl[r].rpc;
            step();
            chk($sformatf("v%0d_valid", r), 64'(bus.valid_o),   64'(tbl[r].vld));
            chk($sformatf("v%0d_pc_o", r),   bus.pc_o,           tbl[r].pco);
            chk($sformatf("v%0d_instr", r),  64'(bus.instr_o),   64'(tbl[r].ins));
            chk($sformatf("v%0d_addr", r),   64'(bus.imem_addr), 64'(tbl[r].addr));
            chk($sformatf("v%0d_cnt", r),    64'(bus.fetch_cnt), 64'(tbl[r].cnt));
            chk($sformatf("v%0d_halted", r), 64'(bus.halted_o),  64'd0);
            if (tbl[r].push) push_exp(tbl[r].pco, tbl[r].ins);
        end

        // Halt: run from 0 until word 93 (0x174) is zero.
        bus.redirect = 1'b0;
        bus.ready_i  = 1'b1;
        for (int k = 0; k < 93; k++) begin
            step();
            chk("run_valid", 64'(bus.valid_o), 64'd1);
            chk("run_pc_o",  bus.pc_o,         64'(4 * k));
            push_exp(64'(4 * k), romw(k));
        end
        chk("run_instr_last", 64'(bus.instr_o), 64'(romw(92)));
        for (int k = 0; k < 10; k++) begin
            step();
            chk("halt_halted", 64'(bus.halted_o),  64'd1);
            chk("halt_valid",  64'(bus.valid_o),   64'd0);
            chk("halt_pc",     dut.pc,             64'h174);
            chk("halt_addr",   64'(bus.imem_addr), 64'h5D);
            chk("halt_cnt",    64'(bus.fetch_cnt), 64'd100);
        end

        bus.redirect    = 1'b1;
        bus.redirect_pc = 64'd0;
        step();
        bus.redirect = 1'b0;
        chk("unhalt_halted", 64'(bus.halted_o), 64'd0);
        chk("unhalt_valid",  64'(bus.valid_o),  64'd0);
        chk("unhalt_addr",   64'(bus.imem_addr), 64'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rerun_valid", 64'(bus.valid_o), 64'd1);
            chk("rerun_pc_o",  bus.pc_o,         64'(4 * k));
            push_exp(64'(4 * k), romw(k));
        end
        step();
        chk("stall_pc_o", bus.pc_o, 64'h20);
        bus.ready_i = 1'b0;
        step();
        chk("stall_hold", bus.pc_o, 64'h20);
        chk("stall_cnt",  64'(bus.fetch_cnt), 64'd108);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        // Async reset in the middle of a stalled cycle.
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid",  64'(bus.valid_o),   64'd0);
        chk("areset_pc",     dut.pc,             64'd0);
        chk("areset_addr",   64'(bus.imem_addr), 64'd0);
        chk("areset_cnt",    64'(bus.fetch_cnt), 64'd0);
        chk("areset_halted", 64'(bus.halted_o),  64'd0);
        chk("areset_pc_o",   bus.pc_o,           64'd0);
        #1;
        reset = 1'b0;
        step();
        chk("sb_final", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
